// File: rtl/sdram_avalon_bist.sv
// BIST master for the Avalon SDRAM controller: writes data(a)=a[15:0]^seed over [base..last], then reads it back and checks it.
// Writes are one per cycle; up to MAX_OUTSTANDING reads are kept in flight. Requests are held stable while avm_waitrequest is high.
module sdram_avalon_bist #(
  parameter int AW              = 25,
  parameter int DW              = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] last_addr,
  input  logic [15:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [15:0]   first_err_data,
  output logic          avm_read,
  output logic          avm_write,
  input  logic          avm_waitrequest,
  output logic [AW-1:0] avm_address,
  output logic [1:0]    avm_byteenable,
  output logic [DW-1:0] avm_writedata,
  input  logic          avm_readdatavalid,
  input  logic [DW-1:0] avm_readdata
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, cmp_addr_q, cmp_addr_d;
  logic [AW-1:0] base_q, base_d, last_q, last_d, ferr_addr_q, ferr_addr_d;
  logic [15:0]   seed_q, seed_d, err_q, err_d, ferr_data_q, ferr_data_d;
  logic [3:0]    out_q, out_d;
  logic          ferr_flag_q, ferr_flag_d, pass_q, pass_d, busy_q, done_q;
  logic          wr_acc, rd_acc, ret, miss;
  logic [15:0]   exp_data;

  assign avm_write      = (state_q == S_WRITE);
  assign avm_read       = (state_q == S_READ) && (out_q < OUT_MAX);
  assign avm_address    = (state_q == S_WRITE) ? wr_addr_q :
                          (state_q == S_READ)  ? rd_addr_q : '0;
  assign avm_writedata  = avm_write ? DW'(wr_addr_q[15:0] ^ seed_q) : '0;
  assign avm_byteenable = 2'b11;

  assign wr_acc   = avm_write && !avm_waitrequest;
  assign rd_acc   = avm_read && !avm_waitrequest;
  // Returns with nothing outstanding are dropped so the counter cannot underflow.
  assign ret      = avm_readdatavalid && (out_q != 4'd0);
  assign exp_data = cmp_addr_q[15:0] ^ seed_q;
  assign miss     = ret && (avm_readdata[15:0] != exp_data);

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    cmp_addr_d  = cmp_addr_q;
    base_d      = base_q;
    last_d      = last_q;
    seed_d      = seed_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    ferr_flag_d = ferr_flag_q;
    pass_d      = pass_q;
    out_d       = out_q + {3'b000, rd_acc} - {3'b000, ret};

    if (ret) begin
      cmp_addr_d = cmp_addr_q + AW'(1);
      if (miss) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (!ferr_flag_q) begin
          ferr_flag_d = 1'b1;
          ferr_addr_d = cmp_addr_q;
          ferr_data_d = avm_readdata[15:0];
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WRITE;
          base_d      = base_addr;
          last_d      = last_addr;
          seed_d      = seed;
          wr_addr_d   = base_addr;
          rd_addr_d   = base_addr;
          cmp_addr_d  = base_addr;
          err_d       = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          ferr_flag_d = 1'b0;
          pass_d      = 1'b0;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (wr_addr_q == last_q) begin
            state_d   = S_READ;
            rd_addr_d = base_q;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          if (rd_addr_q == last_q) state_d = S_DRAIN;
          else rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (out_q == 4'd0) begin
          state_d = S_DONE;
          pass_d  = (err_q == 16'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      cmp_addr_q  <= '0;
      base_q      <= '0;
      last_q      <= '0;
      seed_q      <= '0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      ferr_flag_q <= 1'b0;
      out_q       <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      cmp_addr_q  <= cmp_addr_d;
      base_q      <= base_d;
      last_q      <= last_d;
      seed_q      <= seed_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      ferr_flag_q <= ferr_flag_d;
      out_q       <= out_d;
      pass_q      <= pass_d;
      busy_q      <= (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
    end
  end
endmodule

// File: tb/tb_sdram_avalon_bist.sv
// Bench for sdram_avalon_bist: vector table of runs against a memory slave with latency, stalls and data corruption.
// Writes and reads are checked against queues of expected transfers; end-of-run status against table expectations.
module tb_sdram_avalon_bist;
  localparam int AW   = 25;
  localparam int DW   = 16;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          reset_n, start;
  logic [AW-1:0] base_addr, last_addr;
  logic [15:0]   seed;
  logic          busy, done, pass;
  logic [15:0]   err_count, first_err_data;
  logic [AW-1:0] first_err_addr;
  logic          avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [AW-1:0] avm_address;
  logic [1:0]    avm_byteenable;
  logic [DW-1:0] avm_writedata, avm_readdata;

  always #5 clk = ~clk;

  sdram_avalon_bist #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .last_addr(last_addr), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .avm_read(avm_read), .avm_write(avm_write), .avm_waitrequest(avm_waitrequest),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata)
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] last;
    logic [15:0]   seed;
    int            lat;
    bit            stall;
    bit            poke;
    bit            chk_time;
    bit            corrupt;
    int            words;
    int            exp_err;
    logic [AW-1:0] exp_faddr;
    logic [15:0]   exp_fdata;
    bit            exp_pass;
  } vec_t;

  typedef struct { int t; logic [15:0] d; } ret_t;
  typedef struct { logic [AW-1:0] a; logic [15:0] d; } wr_t;

  vec_t          vecs[6];
  wr_t           wq[$];
  logic [AW-1:0] raq[$];
  ret_t          pipe[$];
  logic [15:0]   mem [logic [AW-1:0]];

  int total = 0, bad = 0, cyc = 0;
  int lat = 2, wr_cnt = 0, rd_cnt = 0, stw = 0, str = 0, tb_out = 0, peak = 0;
  int first_wr_cyc = 0, first_rd_cyc = 0, start_cyc = 0;
  bit stall_en = 1'b0, corrupt_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got unexpected transfer want none", nm);
  endtask

  // Memory slave: acceptance is decided mid-cycle, read data returns lat cycles after acceptance.
  initial begin
    wr_t           w;
    ret_t          r;
    logic [AW-1:0] a;
    logic [15:0]   d;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      avm_waitrequest   = 1'b0;
      if (!reset_n) begin
        pipe.delete();
        tb_out = 0;
      end else begin
        if (tb_out >= MAXO) chk("rd_at_limit", 32'(avm_read), 32'd0);
        if (avm_read && avm_write) fail("rd_wr_both");
        if (pipe.size() > 0 && pipe[0].t <= cyc) begin
          r = pipe.pop_front();
          avm_readdatavalid = 1'b1;
          avm_readdata      = r.d;
          tb_out--;
        end
        if (stall_en && avm_write && wr_cnt == 4 && stw < 3 && wq.size() > 0) begin
          avm_waitrequest = 1'b1;
          stw++;
          chk("stall_wr_addr", 32'(avm_address), 32'(wq[0].a));
          chk("stall_wr_data", 32'(avm_writedata), 32'(wq[0].d));
        end
        if (stall_en && avm_read && rd_cnt == 1 && str < 3 && raq.size() > 0) begin
          avm_waitrequest = 1'b1;
          str++;
          chk("stall_rd_addr", 32'(avm_address), 32'(raq[0]));
        end
        if (avm_write && !avm_waitrequest) begin
          if (wq.size() == 0) fail("wr_extra");
          else begin
            w = wq.pop_front();
            chk("wr_addr", 32'(avm_address), 32'(w.a));
            chk("wr_data", 32'(avm_writedata), 32'(w.d));
          end
          mem[avm_address] = avm_writedata[15:0];
          if (wr_cnt == 0) first_wr_cyc = cyc;
          wr_cnt++;
        end
        if (avm_read && !avm_waitrequest) begin
          if (raq.size() == 0) fail("rd_extra");
          else begin
            a = raq.pop_front();
            chk("rd_addr", 32'(avm_address), 32'(a));
          end
          d = mem.exists(avm_address) ? mem[avm_address] : 16'hDEAD;
          if (corrupt_en && avm_address == 25'h13) d = 16'h0000;
          if (corrupt_en && avm_address == 25'h18) d = ~d;
          r.t = cyc + lat;
          r.d = d;
          pipe.push_back(r);
          tb_out++;
          if (tb_out > peak) peak = tb_out;
          if (rd_cnt == 0) first_rd_cyc = cyc;
          rd_cnt++;
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_faddr"}, 32'(first_err_addr), 32'd0);
    chk({tag, "_fdata"}, 32'(first_err_data), 32'd0);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_write"}, 32'(avm_write), 32'd0);
    chk({tag, "_addr"}, 32'(avm_address), 32'd0);
    chk({tag, "_wdata"}, 32'(avm_writedata), 32'd0);
    chk({tag, "_be"}, 32'(avm_byteenable), 32'd3);
  endtask

  task automatic launch(input vec_t v);
    logic [AW-1:0] a;
    wr_t           w;
    @(negedge clk);
    #2;
    wq.delete();
    raq.delete();
    mem.delete();
    wr_cnt = 0; rd_cnt = 0; stw = 0; str = 0; peak = 0;
    lat = v.lat; stall_en = v.stall; corrupt_en = v.corrupt;
    for (int i = 0; i < v.words; i++) begin
      a   = v.base + AW'(i);
      w.a = a;
      w.d = a[15:0] ^ v.seed;
      wq.push_back(w);
      raq.push_back(a);
    end
    base_addr = v.base; last_addr = v.last; seed = v.seed;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    #2;
    start = 1'b0;
    if (v.chk_time) begin
      chk("busy_cycle1", 32'(busy), 32'd1);
      chk("done_cycle1", 32'(done), 32'd0);
    end
    if (v.poke) begin
      repeat (2) @(negedge clk);
      #2;
      base_addr = 25'h777;
      start = 1'b1;
      @(negedge clk);
      #2;
      start = 1'b0;
      base_addr = v.base;
    end
  endtask

  task automatic finish_run(input vec_t v, input int idx);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #2;
    $display("run %0d: %0d writes, %0d reads", idx, wr_cnt, rd_cnt);
    chk("done", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("pass", 32'(pass), 32'(v.exp_pass));
    chk("err_count", 32'(err_count), 32'(v.exp_err));
    chk("first_err_addr", 32'(first_err_addr), 32'(v.exp_faddr));
    chk("first_err_data", 32'(first_err_data), 32'(v.exp_fdata));
    chk("n_writes", 32'(wr_cnt), 32'(v.words));
    chk("n_reads", 32'(rd_cnt), 32'(v.words));
    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("raq_left", 32'(raq.size()), 32'd0);
    chk("outstanding_end", 32'(tb_out), 32'd0);
    if (v.chk_time) begin
      chk("first_write_cycle", 32'(first_wr_cyc - start_cyc), 32'd1);
      chk("first_read_cycle", 32'(first_rd_cyc - start_cyc), 32'(v.words + 1));
    end
    if (v.stall) begin
      chk("wr_stall_cycles", 32'(stw), 32'd3);
      chk("rd_stall_cycles", 32'(str), 32'd3);
    end
    if (v.lat >= 10) chk("peak_outstanding", 32'(peak), 32'(MAXO));
    repeat (3) @(negedge clk);
    #2;
    chk("done_held", 32'(done), 32'd1);
    chk("pass_held", 32'(pass), 32'(v.exp_pass));
  endtask

  initial begin
    int n;
    vecs[0] = '{base: 25'h10, last: 25'h1F, seed: 16'hA5A5, lat: 2, stall: 0, poke: 0, chk_time: 1, corrupt: 0,
                words: 16, exp_err: 0, exp_faddr: 25'h0, exp_fdata: 16'h0, exp_pass: 1};
    vecs[1] = '{base: 25'h10, last: 25'h1F, seed: 16'h1234, lat: 2, stall: 1, poke: 1, chk_time: 0, corrupt: 0,
                words: 16, exp_err: 0, exp_faddr: 25'h0, exp_fdata: 16'h0, exp_pass: 1};
    vecs[2] = '{base: 25'h100, last: 25'h11F, seed: 16'h0F0F, lat: 10, stall: 0, poke: 0, chk_time: 0, corrupt: 0,
                words: 32, exp_err: 0, exp_faddr: 25'h0, exp_fdata: 16'h0, exp_pass: 1};
    vecs[3] = '{base: 25'h10, last: 25'h1F, seed: 16'hA5A5, lat: 2, stall: 0, poke: 0, chk_time: 0, corrupt: 1,
                words: 16, exp_err: 2, exp_faddr: 25'h13, exp_fdata: 16'h0000, exp_pass: 0};
    vecs[4] = '{base: 25'h1FFFFFE, last: 25'h1, seed: 16'h5A5A, lat: 2, stall: 0, poke: 0, chk_time: 0, corrupt: 0,
                words: 4, exp_err: 0, exp_faddr: 25'h0, exp_fdata: 16'h0, exp_pass: 1};
    vecs[5] = '{base: 25'h5, last: 25'h5, seed: 16'hFFFF, lat: 2, stall: 0, poke: 0, chk_time: 1, corrupt: 0,
                words: 1, exp_err: 0, exp_faddr: 25'h0, exp_fdata: 16'h0, exp_pass: 1};

    reset_n = 1'b1; start = 1'b0; base_addr = '0; last_addr = '0; seed = '0;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk_reset("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i]);
      finish_run(vecs[i], i);
    end

    // Reset while two long-latency reads are in flight, then a clean rerun.
    launch(vecs[2]);
    n = 0;
    while (rd_cnt < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    chk("pre_reset_outstanding", 32'(tb_out), 32'd2);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset("midread");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    launch(vecs[0]);
    finish_run(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
